// File: rtl/obi_rr_arbiter_pkg.sv
// obi_rr_arbiter_pkg: shared OBI subordinate types and arbiter constants.
package obi_rr_arbiter_pkg;
   localparam int unsigned ArbMaxTrans = 4;
   localparam int unsigned ArbMaxMgr = 8;
   localparam int unsigned IdWidth = 1;
   typedef logic [$clog2(ArbMaxMgr)-1:0] arb_idx_t;
   typedef enum logic {UNLOCKED, LOCKED} lock_e;
   typedef struct packed {
      logic [31:0]        addr;
      logic               we;
      logic [3:0]         be;
      logic [31:0]        wdata;
      logic [IdWidth-1:0] aid;
      logic               a_optional;
   } sbr_obi_a_t;
   typedef struct packed {
      logic       req;
      sbr_obi_a_t a;
   } sbr_obi_req_t;
   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } sbr_obi_r_t;
   typedef struct packed {
      logic       gnt;
      logic       rvalid;
      sbr_obi_r_t r;
   } sbr_obi_rsp_t;
endpackage

// File: rtl/obi_id_fifo.sv
// obi_id_fifo: synchronous FIFO holding the manager index of each outstanding transaction.
module obi_id_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 1,
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);
   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wr, r_rd;
   logic [CntW-1:0]  r_cnt;
   logic             w_push, w_pop;
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction
   assign full_o  = (r_cnt == CntW'(Depth));
   assign empty_o = (r_cnt == '0);
   assign count_o = r_cnt;
   assign data_o  = r_mem[r_rd];
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr] <= data_i;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= ptr_inc(r_wr);
         if (w_pop) r_rd <= ptr_inc(r_rd);
         r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
      end
   end
endmodule

// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin share of one OBI subordinate among NumMgr managers,
// responses routed back in order through an ID FIFO.
module obi_rr_arbiter
   import obi_rr_arbiter_pkg::*;
#(
   parameter int unsigned NumMgr = 2,
   parameter int unsigned MaxTrans = ArbMaxTrans,
   localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1,
   localparam int unsigned CntW = $clog2(MaxTrans + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NumMgr-1:0]        mgr_req_i,
   input  logic [NumMgr-1:0][31:0]  mgr_addr_i,
   input  logic [NumMgr-1:0]        mgr_we_i,
   input  logic [NumMgr-1:0][3:0]   mgr_be_i,
   input  logic [NumMgr-1:0][31:0]  mgr_wdata_i,
   output logic [NumMgr-1:0]        mgr_gnt_o,
   output logic [NumMgr-1:0]        mgr_rvalid_o,
   output logic [NumMgr-1:0][31:0]  mgr_rdata_o,
   output logic [NumMgr-1:0]        mgr_err_o,
   output sbr_obi_req_t             sbr_req_o,
   input  sbr_obi_rsp_t             sbr_rsp_i,
   output logic                     busy_o,
   output logic                     spurious_o
);
   lock_e            r_state, w_state_nxt;
   logic [IdxW-1:0]  r_sel, r_rr_ptr, w_rr_sel, w_sel, w_idx, w_head;
   logic [CntW-1:0]  w_count;
   logic             w_full, w_empty, w_hs, w_pop, r_spurious;
   always_comb begin
      w_rr_sel = r_rr_ptr;
      w_idx = '0;
      for (int k = NumMgr - 1; k >= 0; k--) begin
         w_idx = IdxW'((int'(r_rr_ptr) + k) % NumMgr);
         if (mgr_req_i[w_idx]) w_rr_sel = w_idx;
      end
   end
   // A stalled address phase keeps its manager until granted
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= UNLOCKED;
      else r_state <= w_state_nxt;
   end
   always_comb begin
      w_state_nxt = (r_state == UNLOCKED) ? ((sbr_req_o.req & ~sbr_rsp_i.gnt) ? LOCKED : UNLOCKED)
                                          : (w_hs ? UNLOCKED : LOCKED);
   end
   always_comb begin
      w_sel = (r_state == LOCKED) ? r_sel : w_rr_sel;
   end
   always_comb begin
      sbr_req_o = '0;
      sbr_req_o.req = ~w_full & mgr_req_i[w_sel];
      sbr_req_o.a.addr = mgr_addr_i[w_sel];
      sbr_req_o.a.we = mgr_we_i[w_sel];
      sbr_req_o.a.be = mgr_be_i[w_sel];
      sbr_req_o.a.wdata = mgr_wdata_i[w_sel];
      sbr_req_o.a.aid = IdWidth'(w_sel);
   end
   assign w_hs = sbr_req_o.req & sbr_rsp_i.gnt;
   assign w_pop = sbr_rsp_i.rvalid & ~w_empty;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sel      <= '0;
         r_rr_ptr   <= '0;
         r_spurious <= 1'b0;
      end else begin
         if (r_state == UNLOCKED && w_state_nxt == LOCKED) r_sel <= w_sel;
         if (w_hs) r_rr_ptr <= (w_sel == IdxW'(NumMgr - 1)) ? '0 : w_sel + 1'b1;
         if (sbr_rsp_i.rvalid & w_empty) r_spurious <= 1'b1;
      end
   end
   obi_id_fifo #(.Depth(MaxTrans), .Width(IdxW)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_hs),
      .pop_i   (w_pop),
      .data_i  (w_sel),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (w_count)
   );
   assign mgr_gnt_o    = w_hs ? (NumMgr'(1) << w_sel) : '0;
   assign mgr_rvalid_o = w_pop ? (NumMgr'(1) << w_head) : '0;
   assign mgr_err_o    = (w_pop & sbr_rsp_i.r.err) ? (NumMgr'(1) << w_head) : '0;
   assign mgr_rdata_o  = {NumMgr{sbr_rsp_i.r.rdata}};
   assign busy_o       = (w_count != '0);
   assign spurious_o   = r_spurious;
   a_lock_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
      (r_state == LOCKED) |-> mgr_req_i[r_sel]);
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb_obi_rr_arbiter: randomized managers and subordinate against a round-robin reference model,
// with a response scoreboard checked by an independent monitor.
module tb_obi_rr_arbiter;
   import obi_rr_arbiter_pkg::*;
   localparam int NM = 3;
   localparam int MT = 4;
   logic clk_i = 1'b0, rst_i = 1'b1;
   logic [NM-1:0] mgr_req_i = '0, mgr_we_i = '0;
   logic [NM-1:0][31:0] mgr_addr_i = '0, mgr_wdata_i = '0;
   logic [NM-1:0][3:0] mgr_be_i = '0;
   logic [NM-1:0] mgr_gnt_o, mgr_rvalid_o, mgr_err_o;
   logic [NM-1:0][31:0] mgr_rdata_o;
   sbr_obi_req_t sbr_req_o;
   sbr_obi_rsp_t sbr_rsp_i = '0;
   logic busy_o, spurious_o;
   typedef struct {
      int          mgr;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sbq[$];
   logic [31:0] subq[$];
   int checks = 0, errors = 0;
   int n_out = 0, last_g = NM - 1, stalled = -1;
   logic [NM-1:0] gflag = '0;
   obi_rr_arbiter #(.NumMgr(NM), .MaxTrans(MT)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .mgr_req_i(mgr_req_i), .mgr_addr_i(mgr_addr_i),
      .mgr_we_i(mgr_we_i), .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
      .mgr_gnt_o(mgr_gnt_o), .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o),
      .mgr_err_o(mgr_err_o), .sbr_req_o(sbr_req_o), .sbr_rsp_i(sbr_rsp_i),
      .busy_o(busy_o), .spurious_o(spurious_o)
   );
   always #5 clk_i = ~clk_i;
   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return a ^ 32'hA5A5_0F0F;
   endfunction
   function automatic logic mem_err(input logic [31:0] a);
      return a[5:2] == 4'hF;
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask
   // Reference arbitration: a presented-but-ungranted manager keeps the port, otherwise
   // the first requester after the last granted one wins; at most MT outstanding.
   always @(negedge clk_i) if (!rst_i) begin
      int w;
      bit pres, hs;
      w = stalled;
      if (w < 0)
         for (int k = NM; k >= 1; k--) if (mgr_req_i[(last_g + k) % NM]) w = (last_g + k) % NM;
      pres = (n_out < MT) && (w >= 0);
      chk("sbr_req", sbr_req_o.req, pres);
      chk("busy", busy_o, n_out != 0);
      if (pres) begin
         chk("addr", sbr_req_o.a.addr, mgr_addr_i[w]);
         chk("we", sbr_req_o.a.we, mgr_we_i[w]);
         chk("be", sbr_req_o.a.be, mgr_be_i[w]);
         chk("wdata", sbr_req_o.a.wdata, mgr_wdata_i[w]);
         chk("aid", sbr_req_o.a.aid, w % 2);
      end
      hs = pres && sbr_rsp_i.gnt;
      chk("gnt", mgr_gnt_o, hs ? (1 << w) : 0);
      if (hs) begin
         sbq.push_back('{w, mem_rd(mgr_addr_i[w]), mem_err(mgr_addr_i[w])});
         subq.push_back(sbr_req_o.a.addr);
         last_g = w;
         stalled = -1;
         gflag[w] = 1'b1;
      end else if (pres) stalled = w;
      n_out = n_out + int'(hs) - int'(sbr_rsp_i.rvalid && n_out > 0);
   end
   always @(negedge clk_i) if (!rst_i) begin
      exp_t e;
      if (sbr_rsp_i.rvalid && sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("rvalid", mgr_rvalid_o, 1 << e.mgr);
         chk("err", mgr_err_o, e.err ? (1 << e.mgr) : 0);
         chk("rdata", mgr_rdata_o[e.mgr], e.rdata);
      end else chk("rvalid_idle", mgr_rvalid_o, 0);
   end
   task automatic step(input int p_req, input int p_gnt, input int p_rv, input bit force_rv = 1'b0);
      logic [31:0] a;
      @(posedge clk_i); #1;
      for (int i = 0; i < NM; i++) if (gflag[i] || !mgr_req_i[i]) begin
         gflag[i] = 1'b0;
         mgr_req_i[i] = $urandom_range(99) < p_req;
         mgr_addr_i[i] = $urandom & 32'hFFFF_FFFC;
         mgr_we_i[i] = 1'($urandom_range(1));
         mgr_be_i[i] = 4'($urandom);
         mgr_wdata_i[i] = $urandom;
      end
      sbr_rsp_i.gnt = $urandom_range(99) < p_gnt;
      sbr_rsp_i.r.rdata = $urandom;
      sbr_rsp_i.r.err = 1'($urandom_range(1));
      sbr_rsp_i.rvalid = 1'b0;
      if (subq.size() > 0 && $urandom_range(99) < p_rv) begin
         a = subq.pop_front();
         sbr_rsp_i.rvalid = 1'b1;
         sbr_rsp_i.r.rdata = mem_rd(a);
         sbr_rsp_i.r.err = mem_err(a);
      end else if (force_rv) sbr_rsp_i.rvalid = 1'b1;
   endtask
   task automatic do_reset();
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      mgr_req_i = '0;
      sbr_rsp_i = '0;
      sbq.delete();
      subq.delete();
      n_out = 0;
      last_g = NM - 1;
      stalled = -1;
      gflag = '0;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_busy", busy_o, 0);
      chk("rst_spurious", spurious_o, 0);
      chk("rst_req", sbr_req_o.req, 0);
      chk("rst_rvalid", mgr_rvalid_o, 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while ((sbq.size() > 0 || mgr_req_i != '0) && n < 300) begin
         step(0, 100, 100);
         @(negedge clk_i);
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual %0d required below 300", n);
      end
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end
   initial begin
      do_reset();
      repeat (3000) step(60, 70, 50);
      drain();
      @(posedge clk_i); #1;
      mgr_req_i = '0;
      mgr_req_i[1] = 1'b1;
      mgr_addr_i[1] = 32'h1000_0010;
      sbr_rsp_i = '0;
      @(posedge clk_i); #1;
      mgr_req_i[0] = 1'b1;
      mgr_addr_i[0] = 32'h2000_0020;
      @(negedge clk_i) chk("lock_addr1", sbr_req_o.a.addr, 32'h1000_0010);
      @(posedge clk_i); #1;
      @(negedge clk_i) chk("lock_addr2", sbr_req_o.a.addr, 32'h1000_0010);
      @(posedge clk_i); #1;
      sbr_rsp_i.gnt = 1'b1;
      @(negedge clk_i) chk("lock_gnt1", mgr_gnt_o, 3'b010);
      @(posedge clk_i); #1;
      mgr_req_i[1] = 1'b0;
      gflag[1] = 1'b0;
      @(negedge clk_i) chk("lock_gnt0", mgr_gnt_o, 3'b001);
      @(posedge clk_i); #1;
      mgr_req_i = '0;
      gflag = '0;
      sbr_rsp_i.gnt = 1'b0;
      drain();
      repeat (8) step(100, 100, 0);
      @(negedge clk_i);
      chk("full_req", sbr_req_o.req, 0);
      chk("full_busy", busy_o, 1);
      step(100, 100, 100);
      @(negedge clk_i) chk("nobypass_req", sbr_req_o.req, 0);
      step(100, 100, 0);
      @(negedge clk_i) chk("refill_gnt", |mgr_gnt_o, 1);
      step(100, 100, 0);
      @(negedge clk_i) chk("refull_req", sbr_req_o.req, 0);
      drain();
      step(0, 0, 0, 1'b1);
      step(0, 0, 0);
      @(negedge clk_i) chk("spurious_set", spurious_o, 1);
      repeat (3) step(0, 0, 0);
      @(negedge clk_i) chk("spurious_sticky", spurious_o, 1);
      do_reset();
      repeat (2) step(100, 100, 0);
      @(negedge clk_i) chk("mid_busy", busy_o, 1);
      do_reset();
      step(0, 0, 0, 1'b1);
      step(0, 0, 0);
      @(negedge clk_i) chk("post_rst_spurious", spurious_o, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Shares one OBI subordinate port, e.g. SRAM, between NumMgr OBI managers (default instr + data) using round-robin arbitration.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to the manager that issued it.
- Sits between the core/manager side of the interconnect and a single subordinate that uses the sbr_obi_req_t / sbr_obi_rsp_t types.

Parameters:
- NumMgr, 2, number of requesting managers (2..8).
- MaxTrans, 4, maximum outstanding (granted, not yet responded) transactions; power of two, ≥1.
- IdxW, $clog2(NumMgr) (min 1), derived; width of the manager index.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- mgr_req_i  in  NumMgr  per-manager request.
- mgr_addr_i  in  NumMgr×32  per-manager address.
- mgr_we_i  in  NumMgr  write enable.
- mgr_be_i  in  NumMgr×4  byte enables.
- mgr_wdata_i  in  NumMgr×32  write data.
- mgr_gnt_o  out  NumMgr  per-manager grant.
- mgr_rvalid_o  out  NumMgr  per-manager response valid.
- mgr_rdata_o  out  NumMgr×32  response data, broadcast to all managers.
- mgr_err_o  out  NumMgr  response error.
- sbr_req_o  out  sbr_obi_req_t  request to the subordinate.
- sbr_rsp_i  in  sbr_obi_rsp_t  response from the subordinate.
- busy_o  out  1  one or more transactions outstanding.
- spurious_o  out  1  sticky: rvalid was seen while the FIFO was empty.

Behaviour:
- Reset: all outputs 0, lock_q=0, sel_q=0, rr_ptr_q=0, FIFO empty (count 0), spurious_o=0. Reset mid-transaction discards the FIFO contents; responses arriving after reset count as spurious.
- Issue allowed: can_issue = (count < MaxTrans). There is no full-with-pop bypass.
- Selection:
  - When lock_q=0, sel = first manager with req=1, searching from rr_ptr_q upward and wrapping modulo NumMgr.
  - When lock_q=1, sel = sel_q.
- Subordinate request: sbr_req_o.req = can_issue & mgr_req_i[sel]. The a-channel fields carry the sel manager's addr/we/be/wdata. aid = sel truncated to IdWidth (1 bit at default cfg); a_optional=0.
- Grant: mgr_gnt_o[sel] = sbr_rsp_i.gnt & sbr_req_o.req, combinational. All other gnt bits are 0.
- Lock FSM, 2 states:
  - UNLOCKED → LOCKED when sbr_req_o.req=1 and gnt=0. Captures sel_q=sel. This keeps the OBI address phase stable until grant.
  - LOCKED → UNLOCKED on handshake (req & gnt).
  - LOCKED holds sel_q even if another manager has a higher round-robin priority.
- Round-robin pointer: on every handshake, rr_ptr_q ← (granted index + 1) mod NumMgr. No change otherwise.
- ID FIFO:
  - Push the granted index on handshake.
  - Pop on sbr_rsp_i.rvalid when count>0.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo MaxTrans.
- Response routing:
  - On rvalid with count>0: mgr_rvalid_o[head]=1, mgr_err_o[head]=sbr_rsp_i.err, combinationally in the same cycle as sbr rvalid (0-cycle added latency).
  - mgr_rdata_o = sbr_rsp_i.r.rdata, unqualified.
- Spurious response: rvalid with count==0 → no manager rvalid; spurious_o set, cleared only by reset.
- busy_o = (count != 0).
- Latency: the arbiter adds no cycles to the request or response path. Throughput is 1 transaction/cycle when the subordinate grants every cycle.
- A manager dropping req while LOCKED is a protocol violation. Behaviour is undefined; flag it with an assertion.

Decomposition:
- soc_pkg gains ArbMaxTrans = 4 and a typedef for the arbiter index. Existing sbr_obi_req_t / sbr_obi_rsp_t / SbrObiCfg are reused.
- One sub-module: obi_id_fifo. It is a synchronous FIFO parameterised by Depth and Width, with push/pop/full/empty/count outputs.

Test Plan:
- Contention: both managers request continuously; subordinate gnt=1 always, rvalid 1 cycle later → grants alternate 0,1,0,1. Each rvalid goes to the matching manager, with rdata = 0xA000_0000+index.
- Lock: mgr1 requests addr 0x1000_0010 with gnt held low for 3 cycles, and mgr0 raises req in cycle 1 → sbr addr stays 0x1000_0010. mgr1 is granted in cycle 3; mgr0 is granted next.
- Full FIFO: MaxTrans=4, gnt=1, rvalid withheld → exactly 4 handshakes, then sbr req=0 and busy_o=1. One rvalid → next grant in the following cycle.
- Simultaneous push/pop at count=4: rvalid on the same cycle as a blocked request → no grant that cycle (no bypass). Grant next cycle; count returns to 4.
- Error/spurious: rvalid with err=1 for mgr0's transaction → mgr_err_o[0]=1. A later rvalid with the FIFO empty → spurious_o=1 and no mgr rvalid.
- Reset mid-operation: rst_i asserted with 2 outstanding → next cycle count=0, busy_o=0, rr_ptr_q=0. A following rvalid → spurious_o=1.
